// File: rtl/flash_spi_pkg.sv
// flash_spi shared types and constants.
// State encoding and reset levels for the flash pins.
package flash_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    TAIL
  } state_t;

  localparam logic FCK_RST = 1'b1;
  localparam logic FCS_RST = 1'b1;

endpackage

// File: rtl/flash_spi_if.sv
// flash_spi register-side bus.
// The VME decoder is master; the SPI engine is slave.
interface flash_spi_if #(
  parameter int WIDTH = 8,
  parameter int DIVW  = 4
);
  logic             ENABLE;
  logic             WS;
  logic             RS;
  logic [WIDTH-1:0] DIN;
  logic [WIDTH-1:0] DOUT;
  logic [DIVW-1:0]  DIV;
  logic             CPOL;
  logic             CPHA;
  logic             CS_HOLD;
  logic             BUSY;
  logic             DONE;
  logic             OVR;

  modport master (
    output ENABLE, WS, RS, DIN, DIV,
    output CPOL, CPHA, CS_HOLD,
    input  DOUT, BUSY, DONE, OVR
  );

  modport slave (
    input  ENABLE, WS, RS, DIN, DIV,
    input  CPOL, CPHA, CS_HOLD,
    output DOUT, BUSY, DONE, OVR
  );
endinterface

// File: rtl/flash_spi_tick.sv
// flash_spi half-period timer.
// One-cycle tick every DIV+1 cycles while running.
module flash_spi_tick #(
  parameter int DIVW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            run,
  input  logic [DIVW-1:0] div,
  output logic            tick
);
  logic [DIVW-1:0] cnt;

  assign tick = run && (cnt == '0);

  // reload on start and on every tick, else count down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start || tick) begin
      cnt <= div;
    end else if (run) begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/flash_spi_master.sv
// flash_spi_master: parametrised SPI master
// for the configuration-flash port.
module flash_spi_master
  import flash_spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIVW  = 4
) (
  input  logic      CLK,
  input  logic      RSTn,
  flash_spi_if.slave bus,
  input  logic      SI,
  output wire       SO,
  output wire       FCK,
  output wire       FCS
);
  localparam int TCW = $clog2(2*WIDTH+2);
  localparam logic [TCW-1:0] LAST =
    TCW'(2*WIDTH-1);

  state_t           st_q, st_n;
  logic             fck_q, fck_n;
  logic             fcs_q, fcs_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             ovr_q, ovr_n;
  logic [WIDTH-1:0] os_q, os_n;
  logic [WIDTH-1:0] is_q, is_n;
  logic [WIDTH-1:0] dout_q, dout_n;
  logic [TCW-1:0]   tcnt_q, tcnt_n;
  logic [DIVW-1:0]  div_q, div_n;
  logic             cpol_q, cpol_n;
  logic             cpha_q, cpha_n;

  logic            start;
  logic            tick;
  logic [DIVW-1:0] tk_div;
  logic            lead;
  logic            smp;
  logic            shf;

  assign start  = (st_q == IDLE) &&
                  bus.WS && bus.ENABLE;
  assign tk_div = start ? bus.DIV : div_q;

  flash_spi_tick #(.DIVW(DIVW)) u_tick (
    .clk   (CLK),
    .rst_n (RSTn),
    .start (start),
    .run   (st_q != IDLE),
    .div   (tk_div),
    .tick  (tick)
  );

  // state and datapath registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      st_q   <= IDLE;
      fck_q  <= FCK_RST;
      fcs_q  <= FCS_RST;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      os_q   <= '0;
      is_q   <= '0;
      dout_q <= '0;
      tcnt_q <= '0;
      div_q  <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
    end else begin
      st_q   <= st_n;
      fck_q  <= fck_n;
      fcs_q  <= fcs_n;
      busy_q <= busy_n;
      done_q <= done_n;
      ovr_q  <= ovr_n;
      os_q   <= os_n;
      is_q   <= is_n;
      dout_q <= dout_n;
      tcnt_q <= tcnt_n;
      div_q  <= div_n;
      cpol_q <= cpol_n;
      cpha_q <= cpha_n;
    end
  end

  // next-state, edge sequencing and abort
  always_comb begin
    st_n   = st_q;
    fck_n  = fck_q;
    fcs_n  = fcs_q;
    busy_n = busy_q;
    done_n = 1'b0;
    ovr_n  = ovr_q;
    os_n   = os_q;
    is_n   = is_q;
    dout_n = dout_q;
    tcnt_n = tcnt_q;
    div_n  = div_q;
    cpol_n = cpol_q;
    cpha_n = cpha_q;
    // toggle tcnt_q+1 is odd -> leading edge
    lead = ~tcnt_q[0];
    smp  = cpha_q ? ~lead : lead;
    shf  = cpha_q ? (lead && tcnt_q != '0)
                  : ~lead;

    if (bus.WS && busy_q) begin
      ovr_n = 1'b1;
    end else if (bus.RS) begin
      ovr_n = 1'b0;
    end

    unique case (st_q)
      IDLE: begin
        fck_n = bus.CPOL;
        if (!bus.CS_HOLD) fcs_n = 1'b1;
        if (start) begin
          os_n   = bus.DIN;
          div_n  = bus.DIV;
          cpol_n = bus.CPOL;
          cpha_n = bus.CPHA;
          fcs_n  = 1'b0;
          busy_n = 1'b1;
          tcnt_n = '0;
          st_n   = SETUP;
        end
      end
      SETUP, SHIFT: begin
        if (tick) begin
          tcnt_n = tcnt_q + 1'b1;
          fck_n  = ~fck_q;
          if (smp) is_n = {is_q[WIDTH-2:0], SI};
          if (shf) os_n = {os_q[WIDTH-2:0], 1'b0};
          if (st_q == SETUP) begin
            st_n = SHIFT;
          end else if (tcnt_q == LAST) begin
            st_n = TAIL;
          end
        end
      end
      TAIL: begin
        if (tick) begin
          done_n = 1'b1;
          dout_n = is_q;
          busy_n = 1'b0;
          fcs_n  = ~bus.CS_HOLD;
          st_n   = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase

    if (!bus.ENABLE && st_q != IDLE) begin
      st_n   = IDLE;
      fcs_n  = 1'b1;
      busy_n = 1'b0;
      fck_n  = bus.CPOL;
      done_n = 1'b0;
      dout_n = dout_q;
    end
  end

  assign bus.DOUT = dout_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.OVR  = ovr_q;

  assign SO  = bus.ENABLE ? os_q[WIDTH-1] : 1'bz;
  assign FCK = bus.ENABLE ? fck_q : 1'bz;
  assign FCS = bus.ENABLE ? fcs_q : 1'bz;
endmodule

// File: tb/tb_flash_spi_master.sv
// tb_flash_spi_master: directed bench with
// a tiny SPI slave model on the flash pins.
module tb_flash_spi_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  flash_spi_if #(.WIDTH(8), .DIVW(4)) bus();

  wire  so;
  wire  fck;
  wire  fcs;
  logic si;

  pullup   (fck);
  pullup   (fcs);
  pulldown (so);

  flash_spi_master #(.WIDTH(8), .DIVW(4)) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus),
    .SI   (si),
    .SO   (so),
    .FCK  (fck),
    .FCS  (fcs)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int ws_at  = -1;
  int tog_n, tog_first, tog_last;
  int fcs_hi = 0;
  int at, nd;

  logic       lb   = 1'b0;
  logic [7:0] sval = 8'h00;
  int         nfall = 0;
  logic [7:0] so_cap = 8'h00;
  logic [7:0] words [3];

  // slave: presents MSB first, advances on FCK fall
  always @(negedge fck or posedge fcs)
    if (fcs === 1'b1) nfall <= 0;
    else              nfall <= nfall + 1;

  assign si = lb ? so :
              (nfall < 8) ? sval[3'(7 - nfall)] : 1'b0;

  // capture SO on rising FCK, clear on FCS fall
  always @(posedge fck or negedge fcs)
    if (fck === 1'b1 && fcs === 1'b0)
      so_cap <= {so_cap[6:0], so};
    else if (fcs === 1'b0)
      so_cap <= 8'h00;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h",
                  tag, got, exp);
  endtask

  task automatic go(input logic [7:0] d);
    bus.DIN = d;
    bus.WS  = 1'b1;
    @(negedge clk);
    bus.WS  = 1'b0;
    cyc = 1;
  endtask

  task automatic run_to(input int lim,
                        output int done_at);
    logic pf;
    done_at   = -1;
    pf        = fck;
    tog_n     = 0;
    tog_first = -1;
    tog_last  = -1;
    while (cyc < lim) begin
      if (bus.DONE === 1'b1) begin
        done_at = cyc;
        break;
      end
      if (cyc == ws_at) begin
        bus.WS  = 1'b1;
        bus.DIN = 8'hFF;
      end else begin
        bus.WS = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (fcs !== 1'b0) fcs_hi++;
      if (fck !== pf) begin
        tog_n++;
        if (tog_first < 0) tog_first = cyc;
        tog_last = cyc;
      end
      pf = fck;
    end
    if (done_at < 0 && bus.DONE === 1'b1)
      done_at = cyc;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    words = '{8'h03, 8'h00, 8'h10};
    bus.ENABLE  = 1'b1;
    bus.WS      = 1'b0;
    bus.RS      = 1'b0;
    bus.DIN     = '0;
    bus.DIV     = '0;
    bus.CPOL    = 1'b0;
    bus.CPHA    = 1'b0;
    bus.CS_HOLD = 1'b0;

    @(negedge clk);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_ovr",  bus.OVR,  0);
    check("rst_dout", bus.DOUT, 0);
    check("rst_fck",  fck, 1);
    check("rst_fcs",  fcs, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // mode 0, DIV 0
    sval = 8'h3C;
    go(8'hA5);
    check("m0_fcs_c1",  fcs, 0);
    check("m0_busy_c1", bus.BUSY, 1);
    run_to(200, at);
    check("m0_done_cyc", at, 18);
    check("m0_dout", bus.DOUT, 8'h3C);
    check("m0_so",   so_cap, 8'hA5);
    check("m0_fcs_end",  fcs, 1);
    check("m0_busy_end", bus.BUSY, 0);
    @(negedge clk);
    check("m0_done_pulse", bus.DONE, 0);

    // mode 3, DIV 3, loopback
    bus.CPOL = 1'b1;
    bus.CPHA = 1'b1;
    bus.DIV  = 4'd3;
    lb = 1'b1;
    @(negedge clk);
    check("m3_fck_idle", fck, 1);
    go(8'h81);
    run_to(400, at);
    check("m3_done_cyc", at, 69);
    check("m3_tog_n",    tog_n, 16);
    check("m3_tog_first", tog_first, 5);
    check("m3_tog_last",  tog_last, 65);
    check("m3_dout", bus.DOUT, 8'h81);

    // three held words
    bus.CPOL = 1'b0;
    bus.CPHA = 1'b0;
    bus.DIV  = 4'd0;
    lb = 1'b0;
    bus.CS_HOLD = 1'b1;
    @(negedge clk);
    fcs_hi = 0;
    for (int w = 0; w < 3; w++) begin
      go(words[w]);
      run_to(200, at);
      check("cs_done_cyc", at, 18);
      @(negedge clk);
      if (fcs !== 1'b0) fcs_hi++;
    end
    check("cs_fcs_high_cnt", fcs_hi, 0);
    check("cs_fcs_idle", fcs, 0);
    bus.CS_HOLD = 1'b0;
    @(negedge clk);
    check("cs_fcs_release", fcs, 1);

    // overrun during a DIV 1 transfer
    bus.DIV = 4'd1;
    sval = 8'h5A;
    ws_at = 5;
    go(8'h96);
    run_to(200, at);
    ws_at = -1;
    check("ovr_done_cyc", at, 35);
    check("ovr_so",   so_cap, 8'h96);
    check("ovr_dout", bus.DOUT, 8'h5A);
    check("ovr_set",  bus.OVR, 1);
    bus.RS = 1'b1;
    @(negedge clk);
    bus.RS = 1'b0;
    check("ovr_clr", bus.OVR, 0);

    // abort at toggle 7
    bus.DIV = 4'd0;
    go(8'hFF);
    repeat (7) begin
      @(negedge clk);
      cyc++;
    end
    check("ab_fck_t7", fck, 1);
    bus.ENABLE = 1'b0;
    @(negedge clk);
    check("ab_busy", bus.BUSY, 0);
    check("ab_fck_z", fck, 1);
    check("ab_so_z",  so, 0);
    check("ab_fcs_z", fcs, 1);
    nd = 0;
    repeat (30) begin
      if (bus.DONE !== 1'b0) nd++;
      @(negedge clk);
    end
    check("ab_no_done", nd, 0);
    check("ab_dout", bus.DOUT, 8'h5A);
    bus.ENABLE = 1'b1;
    @(negedge clk);

    // async reset mid-shift, then recovery
    sval = 8'h3C;
    go(8'h3C);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", bus.BUSY, 0);
    check("ar_fcs",  fcs, 1);
    check("ar_fck",  fck, 1);
    check("ar_dout", bus.DOUT, 0);
    check("ar_done", bus.DONE, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sval = 8'hC3;
    go(8'h5A);
    run_to(200, at);
    check("ar2_done_cyc", at, 18);
    check("ar2_dout", bus.DOUT, 8'hC3);
    check("ar2_so",   so_cap, 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/flash_spi_master.md
# flash_spi_master

Parametrised SPI master for the configuration-flash port: the next generation of the 8-bit fixed-rate flash shifter. It adds a word width parameter, a programmable FCK divider, all four CPOL/CPHA modes, chip-select generation with hold-across-words for multi-byte commands, and BUSY/DONE/overrun status. It sits between the VME register decoder and the flash pins, and drives the pins only while the CPLD is flash master.

## Interface
- WIDTH, 8: bits per transfer, MSB first (≥2).
- DIVW, 4: width of the DIV input.

- CLK  in  1  system clock, 125 MHz.
- RSTn  in  1  asynchronous reset, active low.
- ENABLE  in  1  1 = CPLD is flash master; 0 tristates SO/FCK/FCS and aborts any transfer.
- WS  in  1  write strobe; starts a transfer with DIN.
- RS  in  1  read strobe; clears OVR.
- DIN  in  WIDTH  transmit word.
- DOUT  out  WIDTH  last received word, updated at DONE.
- DIV  in  DIVW  FCK half-period H = DIV+1 CLK cycles.
- CPOL, CPHA  in  1 each  SPI mode.
- CS_HOLD  in  1  1 = keep FCS low after the transfer.
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle pulse at the end of a transfer.
- OVR  out  1  sticky flag: WS arrived while BUSY.
- SI  in  1  serial data from flash.
- SO  out  1  serial data to flash; Z when !ENABLE.
- FCK  out  1  serial clock; Z when !ENABLE.
- FCS  out  1  flash chip select, active low; Z when !ENABLE.

## Operation
- Reset values: state IDLE; OSREG, ISREG, DOUT = 0; internal FCK = 1; internal FCS = 1; BUSY, DONE, OVR = 0.
- States: IDLE → SETUP → SHIFT → TAIL → IDLE.
- IDLE:
  - Internal FCK tracks CPOL every cycle.
  - If FCS is low and CS_HOLD = 0, FCS goes high the next cycle.
  - WS with ENABLE: latch DIN into OSREG and latch DIV, CPOL, CPHA into shadow registers. These are held for the whole transfer. Set FCS = 0 and BUSY = 1, then go to SETUP.
- SETUP: wait H cycles with FCK = CPOL, then go to SHIFT.
- SHIFT: 2·WIDTH FCK toggles, one every H cycles. Odd toggles are leading edges, even toggles are trailing edges.
  - CPHA = 0: ISREG shifts in SI on leading edges; OSREG shifts left on trailing edges.
  - CPHA = 1: OSREG shifts on leading edges except the first; ISREG shifts in SI on trailing edges.
  - SO = OSREG[WIDTH-1] at all times.
- TAIL: wait H cycles after the last toggle, then in one cycle:
  - DONE = 1 and DOUT ← ISREG;
  - BUSY = 0;
  - FCS ← 1 if CS_HOLD = 0, otherwise FCS stays 0;
  - go to IDLE.
- WS while BUSY is ignored and sets OVR. RS clears OVR. If WS and RS occur in the same cycle, set wins.
- ENABLE = 0 during any non-IDLE state: next cycle is IDLE with FCS = 1, BUSY = 0, FCK = CPOL, no DONE, DOUT unchanged.
- RSTn low during a transfer: immediate asynchronous return to reset values.

## Timing
- WS sampled at cycle 0:
  - FCS low and BUSY high from cycle 1.
  - FCK toggle k (k = 1..2·WIDTH) at cycle 1 + k·H.
  - DONE at cycle 1 + (2·WIDTH+1)·H.
- Example: DIV = 0, WIDTH = 8 gives FCK = 62.5 MHz and DONE at cycle 18.
- A WS in the cycle after DONE is accepted. Back-to-back words with CS_HOLD = 1 keep FCS low continuously.
- DIV = 0 is legal and is the fastest rate. DIV = all-ones gives H = 2^DIVW.

## Structure
- Package flash_spi_pkg: state enum (IDLE, SETUP, SHIFT, TAIL) and the reset constants for FCK and FCS.
- Sub-module flash_spi_tick: half-period down-counter.
  - Loads the shadow DIV on start and on every tick.
  - Emits a one-cycle tick every H cycles while running.
  - The FSM counts ticks with a counter of width $clog2(2·WIDTH+2).

## Test plan
- Mode 0, DIV = 0, DIN = 0xA5, SI returns 0x3C → SO bits 1,0,1,0,0,1,0,1 sampled on rising FCK; DOUT = 0x3C; DONE at cycle 18; FCS high at cycle 18.
- Mode 3 (CPOL = 1, CPHA = 1), DIV = 3, DIN = 0x81 → FCK idles high; 16 toggles 4 cycles apart; DONE at cycle 69; loopback gives DOUT = 0x81.
- CS_HOLD = 1, three words 0x03, 0x00, 0x10 back-to-back → FCS stays low continuously; after CS_HOLD = 0 in IDLE, FCS goes high the following cycle.
- WS pulsed at cycle 5 of a transfer → transfer unaffected, OVR = 1; RS → OVR = 0.
- ENABLE dropped at toggle 7 → SO/FCK/FCS go Z, BUSY = 0 next cycle, no DONE, DOUT unchanged.
- RSTn asserted mid-SHIFT → all outputs at reset values immediately; a fresh WS after release completes normally.
